// File: rtl/pc_redirect_unit_if.sv
// Execute-to-fetch bundle for pc_redirect_unit: EX-stage branch inputs and fetch-side outputs.
// The master side is the pipeline that drives EX and consumes fetch; the slave side is the unit.
interface pc_redirect_unit_if;
    logic        stall;
    logic        ex_valid;
    logic [5:0]  ex_ctrl;
    logic        ex_jalr;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        branch;
    logic [31:0] ALU_result;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        flush;
    logic [31:0] link_pc;
    logic        misaligned;

    modport master (
        output stall, ex_valid, ex_ctrl, ex_jalr, ex_pc, ex_imm, branch, ALU_result,
        input  fetch_pc, fetch_valid, flush, link_pc, misaligned
    );

    modport slave (
        input  stall, ex_valid, ex_ctrl, ex_jalr, ex_pc, ex_imm, branch, ALU_result,
        output fetch_pc, fetch_valid, flush, link_pc, misaligned
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with branch/jump resolution, flush bubbles and jal/jalr link address.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned targets trap to TRAP_VEC instead of being truncated.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input logic               clock,
    input logic               reset,
    pc_redirect_unit_if.slave bus
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
`ifdef PC_MISALIGN_TRAP_EN
        , ST_TRAP
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;

    logic        is_jal, is_branch, is_jalr, taken;
    logic [31:0] target;

    assign is_jal    = (bus.ex_ctrl == 6'b011111);
    assign is_branch = (bus.ex_ctrl[5:3] == 3'b010);
    assign is_jalr   = bus.ex_jalr;
    assign taken     = bus.ex_valid & (is_jal | is_jalr | (is_branch & bus.branch));
    // jalr wins over a jal code so a mis-decoded control word still follows the register target
    assign target    = is_jalr ? {bus.ALU_result[31:1], 1'b0} : bus.ex_pc + bus.ex_imm;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (taken) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (target[1:0] != 2'b00) begin
                        pc_d    = TRAP_VEC;
                        mis_d   = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = target;
                        cnt_d   = FLUSH_LAST;
                        state_d = ST_FLUSH;
                    end
`else
                    pc_d    = {target[31:2], 2'b00};
                    cnt_d   = FLUSH_LAST;
                    state_d = ST_FLUSH;
`endif
                end else if (!bus.stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
`ifdef PC_MISALIGN_TRAP_EN
            ST_TRAP: begin
                cnt_d   = FLUSH_LAST;
                state_d = ST_FLUSH;
            end
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    // Status outputs are registered from the next state so they never glitch on state decode.
    assign valid_d = (state_d == ST_RUN);
`ifdef PC_MISALIGN_TRAP_EN
    assign flush_d = (state_d == ST_FLUSH) || (state_d == ST_TRAP);
`else
    assign flush_d = (state_d == ST_FLUSH);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.fetch_pc    = pc_q;
    assign bus.fetch_valid = valid_q;
    assign bus.flush       = flush_q;
    assign bus.link_pc     = bus.ex_pc + 32'd4;

    logic unused_ok;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.misaligned = mis_q;
    assign unused_ok      = bus.ALU_result[0];
`else
    assign bus.misaligned = 1'b0;
    assign unused_ok      = ^{bus.ALU_result[0], TRAP_VEC, mis_q};
`endif

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter generator and branch-resolution end of the execute interface. Consumes the ALU's `branch` flag and `ALU_result` together with the EX-stage control code, decides whether the instruction redirects control flow, and produces the registered fetch PC. It also produces pipeline flush bubbles and the link address for jal/jalr. Sits between the ALU output and the instruction-fetch stage.

## Interface

- `RESET_PC`, 32'h0000_0000, fetch PC loaded on reset
- `FLUSH_CYCLES`, 2, number of bubble cycles after a redirect (1..7)
- `TRAP_VEC`, 32'h0000_0100, fetch PC after a misaligned target (macro-gated)
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  hold fetch PC (hazard from downstream)
- `ex_valid`  in  1  EX-stage instruction valid this cycle
- `ex_ctrl`  in  6  ALU_Control of the EX instruction
- `ex_jalr`  in  1  EX instruction is jalr (ALU add code 000000)
- `ex_pc`  in  32  PC of the EX instruction
- `ex_imm`  in  32  sign-extended immediate
- `branch`  in  1  ALU branch flag
- `ALU_result`  in  32  ALU result (jalr target)
- `fetch_pc`  out  32  registered fetch address
- `fetch_valid`  out  1  fetch_pc is a valid fetch
- `flush`  out  1  kill younger IF/ID instructions
- `link_pc`  out  32  ex_pc + 4, combinational
- `misaligned`  out  1  sticky misaligned-target flag (macro-gated, else 0)

## Operation

- Decode: is_jal = (ex_ctrl == 6'b011111); is_branch = (ex_ctrl[5:3] == 3'b010); is_jalr = ex_jalr.
- taken = ex_valid & (is_jal | is_jalr | (is_branch & branch)). `branch` is ignored for jal/jalr.
- Target: jal/branch → ex_pc + ex_imm (mod 2^32); jalr → {ALU_result[31:1], 1'b0}. If both is_jalr and is_jal are set, jalr wins.
- FSM states: BOOT, RUN, FLUSH, TRAP (TRAP is present only with the macro).
  - BOOT → RUN on the first clock edge after reset release.
  - RUN: if taken → load target, go to FLUSH with counter = FLUSH_CYCLES-1. Else if !stall → fetch_pc += 4 (wraps at 2^32). Else hold.
  - FLUSH: ex_valid is ignored; counter decrements each cycle; fetch_pc holds; at counter 0 → RUN.
  - TRAP: fetch_pc = TRAP_VEC; go to FLUSH on the next cycle.
- A redirect has priority over `stall`.
- A taken redirect in RUN on the same cycle that stall=1 is still accepted.

## Timing

- Reset values: fetch_pc = RESET_PC, fetch_valid = 0, flush = 0, misaligned = 0, state = BOOT, counter = 0.
- Reset is asynchronous and effective mid-FLUSH or mid-TRAP; all state is abandoned.
- fetch_valid = 1 only in RUN (registered). It is 1 starting the first edge after BOOT.
- Redirect latency: taken sampled at edge N gives fetch_pc = target after edge N. flush = 1 and fetch_valid = 0 for exactly FLUSH_CYCLES cycles starting after edge N. fetch_valid returns to 1 after edge N+FLUSH_CYCLES.
- Sequential increment latency: 1 cycle per +4.
- link_pc has zero latency (combinational from ex_pc).

## Configuration

- `PC_MISALIGN_TRAP_EN` defined:
  - A taken target with target[1:0] != 0 enters TRAP instead of loading the target.
  - misaligned sets and stays set until reset.
  - Sequence: fetch_pc = TRAP_VEC one cycle after the taken edge, then FLUSH as for a normal redirect.
- Not defined:
  - No TRAP state.
  - The target is loaded with bits [1:0] forced to 0.
  - misaligned is tied to 0.

## Test plan

- Reset, release, no stall → fetch_valid 0 during BOOT, then fetch_pc 0, 4, 8, 12 on successive cycles.
- stall=1 for 3 cycles at fetch_pc=8 → fetch_pc holds 8, fetch_valid stays 1; stepping to 12 resumes after release.
- jal: ex_ctrl=011111, ex_pc=0x20, ex_imm=0x10, branch=0 → fetch_pc=0x30 next cycle, flush=1 for 2 cycles, link_pc=0x24.
- beq not taken (ex_ctrl=010000, branch=0) → no flush, pc += 4. Taken with ex_pc=0x40, ex_imm=-8 → fetch_pc=0x38.
- jalr: ex_jalr=1, ex_ctrl=000000, ALU_result=0x0000_0107 → with macro, misaligned=1 and fetch_pc=0x100; without macro, fetch_pc=0x104.
- Assert reset mid-FLUSH → fetch_pc=RESET_PC and flush=0 immediately (asynchronous); fetch_pc=0xFFFF_FFFC increments and wraps to 0.
